// File: rtl/clk_div_pkg.sv
// Shared constants, types and helpers for the multi-channel integer clock divider.
package clk_div_pkg;

  localparam int unsigned CLK_DIV_MIN = 2;

  typedef enum logic {
    IDLE,
    RUN
  } ch_state_e;

  // Length of the high phase for a given ratio; ratios below the minimum behave as the minimum.
  function automatic logic [31:0] clk_div_high(input logic [31:0] ratio);
    logic [31:0] r;
    r = (ratio < 32'(CLK_DIV_MIN)) ? 32'(CLK_DIV_MIN) : ratio;
    return 32'(({1'b0, r} + 33'd1) >> 1);
  endfunction

endpackage

// File: rtl/clk_div_ch.sv
// One divider channel: period counter with a double-buffered ratio applied at period boundaries.
module clk_div_ch
  import clk_div_pkg::*;
#(
  parameter int DIVW    = 16,
  parameter int DEF_DIV = 2
) (
  input  logic            clk,
  input  logic            srst,
  input  logic            en,
  input  logic            load,
  input  logic [DIVW-1:0] ratio,
  input  logic            sync,
  output logic            out,
  output logic            tick,
  output logic            pend
);

  ch_state_e       state_reg, state_next;
  logic [DIVW-1:0] cnt_reg, cnt_next;
  logic [DIVW-1:0] act_reg, act_next;
  logic [DIVW-1:0] nxt_reg, nxt_next;
  logic            pend_reg, pend_next;
  logic            out_reg, out_next;
  logic            tick_reg, tick_next;

  logic [DIVW-1:0] eff;
  logic [DIVW-1:0] high;
  logic [DIVW-1:0] act_applied;
  logic            boundary;

  always_comb begin
    eff         = (act_reg == DIVW'(1)) ? DIVW'(CLK_DIV_MIN) : act_reg;
    high        = DIVW'(clk_div_high(32'(eff)));
    act_applied = pend_reg ? nxt_reg : act_reg;
    // An idle channel re-evaluates every cycle; a running one only on wrap or sync.
    boundary    = (state_reg == IDLE) || sync || (cnt_reg == eff - DIVW'(1));

    state_next = state_reg;
    cnt_next   = cnt_reg;
    act_next   = act_reg;
    nxt_next   = nxt_reg;
    pend_next  = pend_reg;
    out_next   = 1'b0;
    tick_next  = 1'b0;

    if (boundary) begin
      act_next  = act_applied;
      pend_next = 1'b0;
      cnt_next  = '0;
      if (en && (act_applied != '0)) begin
        state_next = RUN;
        out_next   = 1'b1;
        tick_next  = 1'b1;
      end else begin
        state_next = IDLE;
      end
    end else begin
      cnt_next = cnt_reg + DIVW'(1);
      out_next = (cnt_next < high);
    end

    // A load on a boundary edge is captured after the old pending value was consumed.
    if (load) begin
      nxt_next  = ratio;
      pend_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      act_reg   <= DIVW'(DEF_DIV);
      nxt_reg   <= '0;
      pend_reg  <= 1'b0;
      out_reg   <= 1'b0;
      tick_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      act_reg   <= act_next;
      nxt_reg   <= nxt_next;
      pend_reg  <= pend_next;
      out_reg   <= out_next;
      tick_reg  <= tick_next;
    end
  end

  assign out  = out_reg;
  assign tick = tick_reg;
  assign pend = pend_reg;

endmodule

// File: rtl/clk_div.sv
// Multi-channel programmable clock divider: NCH independent channels sharing a sync strobe.
module clk_div
  import clk_div_pkg::*;
#(
  parameter int NCH     = 4,
  parameter int DIVW    = 16,
  parameter int DEF_DIV = 2
) (
  input  logic                fsys,
  input  logic                clk_div_rst,
  input  logic [NCH-1:0]      clk_div_en,
  input  logic [NCH-1:0]      clk_div_load,
  input  logic [NCH*DIVW-1:0] clk_div_ratio,
  input  logic                clk_div_sync,
  output logic [NCH-1:0]      clk_div_out,
  output logic [NCH-1:0]      clk_div_tick,
  output logic [NCH-1:0]      clk_div_pend
);

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ch
      clk_div_ch #(
        .DIVW   (DIVW),
        .DEF_DIV(DEF_DIV)
      ) u_ch (
        .clk  (fsys),
        .srst (clk_div_rst),
        .en   (clk_div_en[gi]),
        .load (clk_div_load[gi]),
        .ratio(clk_div_ratio[gi*DIVW +: DIVW]),
        .sync (clk_div_sync),
        .out  (clk_div_out[gi]),
        .tick (clk_div_tick[gi]),
        .pend (clk_div_pend[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_clk_div.sv
// Self-checking bench for clk_div: phase/period model checked every cycle plus literal sequences.
module tb_clk_div;

  localparam int NCH     = 4;
  localparam int DIVW    = 16;
  localparam int DEF_DIV = 2;

  logic                fsys;
  logic                rst;
  logic [NCH-1:0]      en;
  logic [NCH-1:0]      load;
  logic [NCH*DIVW-1:0] ratio;
  logic                sync;
  logic [NCH-1:0]      out;
  logic [NCH-1:0]      tick;
  logic [NCH-1:0]      pend;

  int errors = 0;
  int checks = 0;

  clk_div #(
    .NCH    (NCH),
    .DIVW   (DIVW),
    .DEF_DIV(DEF_DIV)
  ) dut (
    .fsys         (fsys),
    .clk_div_rst  (rst),
    .clk_div_en   (en),
    .clk_div_load (load),
    .clk_div_ratio(ratio),
    .clk_div_sync (sync),
    .clk_div_out  (out),
    .clk_div_tick (tick),
    .clk_div_pend (pend)
  );

  initial fsys = 1'b0;
  always #5 fsys = ~fsys;

  // Model: each channel is either stopped or at some phase within a period of length m_act.
  bit m_run[NCH];
  int m_phase[NCH];
  int m_act[NCH];
  int m_nxt[NCH];
  bit m_pend[NCH];
  int m_len;
  bit m_bnd;

  always @(posedge fsys) begin
    for (int c = 0; c < NCH; c++) begin
      if (rst) begin
        m_run[c] = 0; m_phase[c] = 0; m_act[c] = DEF_DIV; m_nxt[c] = 0; m_pend[c] = 0;
      end else begin
        m_len = (m_act[c] == 1) ? 2 : m_act[c];
        m_bnd = !m_run[c] || sync || (m_phase[c] == m_len - 1);
        if (m_bnd) begin
          if (m_pend[c]) begin
            m_act[c]  = m_nxt[c];
            m_pend[c] = 0;
          end
          m_run[c]   = en[c] && (m_act[c] != 0);
          m_phase[c] = 0;
        end else begin
          m_phase[c] = m_phase[c] + 1;
        end
        if (load[c]) begin
          m_nxt[c]  = int'(ratio[c*DIVW +: DIVW]);
          m_pend[c] = 1;
        end
      end
    end
  end

  function automatic logic exp_out(int c);
    int len;
    len = (m_act[c] == 1) ? 2 : m_act[c];
    return m_run[c] && (m_phase[c] < (len + 1) / 2);
  endfunction

  function automatic logic exp_tick(int c);
    return m_run[c] && (m_phase[c] == 0);
  endfunction

  task automatic chk(string name, logic got, logic want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %b want %b at %0t", name, got, want, $time);
    end
  endtask

  task automatic compare_all();
    for (int c = 0; c < NCH; c++) begin
      chk($sformatf("model_out%0d", c), out[c], exp_out(c));
      chk($sformatf("model_tick%0d", c), tick[c], exp_tick(c));
      chk($sformatf("model_pend%0d", c), pend[c], logic'(m_pend[c]));
    end
  endtask

  task automatic step();
    @(posedge fsys);
    #1;
    compare_all();
  endtask

  task automatic set_ratio(int c, int v);
    ratio[c*DIVW +: DIVW] = DIVW'(v);
  endtask

  bit e5o[10] = '{1, 1, 1, 0, 0, 1, 1, 1, 0, 0};
  bit e5t[10] = '{1, 0, 0, 0, 0, 1, 0, 0, 0, 0};
  bit e6o[6]  = '{1, 0, 0, 0, 0, 0};

  initial begin
    rst = 1'b1; en = '0; load = '0; ratio = '0; sync = 1'b0;
    step();
    chk("reset_quiet", |{out, tick, pend}, 1'b0);
    rst = 1'b0;
    step();

    $display("scenario: default ratio 2 on channel 0");
    en[0] = 1'b1;
    step(); chk("def_out_c1", out[0], 1'b1); chk("def_tick_c1", tick[0], 1'b1);
    step(); chk("def_out_c2", out[0], 1'b0); chk("def_tick_c2", tick[0], 1'b0);
    step(); chk("def_out_c3", out[0], 1'b1); chk("def_tick_c3", tick[0], 1'b1);
    step(); chk("def_out_c4", out[0], 1'b0); chk("def_tick_c4", tick[0], 1'b0);

    $display("scenario: load 5 while idle then enable");
    en[0] = 1'b0;
    step(); step();
    load[0] = 1'b1; set_ratio(0, 5);
    step(); chk("idle_load_pend", pend[0], 1'b1);
    load[0] = 1'b0;
    step(); chk("idle_apply_pend", pend[0], 1'b0);
    en[0] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      chk($sformatf("r5_out_%0d", k), out[0], logic'(e5o[k]));
      chk($sformatf("r5_tick_%0d", k), tick[0], logic'(e5t[k]));
    end

    $display("scenario: ratio change on running channel 1");
    load[1] = 1'b1; set_ratio(1, 4);
    step(); load[1] = 1'b0;
    step(); en[1] = 1'b1;
    step(); chk("r4_start_tick", tick[1], 1'b1);
    step();
    load[1] = 1'b1; set_ratio(1, 7);
    step(); chk("r4_pend_a", pend[1], 1'b1); chk("r4_out_cnt2", out[1], 1'b0);
    set_ratio(1, 3);
    step(); chk("r4_pend_b", pend[1], 1'b1); chk("r4_out_cnt3", out[1], 1'b0);
    load[1] = 1'b0;
    step(); chk("r3_wrap_tick", tick[1], 1'b1); chk("r3_wrap_out", out[1], 1'b1);
    chk("r3_wrap_pend", pend[1], 1'b0);
    step(); chk("r3_out_p1", out[1], 1'b1); chk("r3_tick_p1", tick[1], 1'b0);
    step(); chk("r3_out_p2", out[1], 1'b0);
    step(); chk("r3_tick_p3", tick[1], 1'b1);

    $display("scenario: drop enable mid-period on channel 2");
    load[2] = 1'b1; set_ratio(2, 6);
    step(); load[2] = 1'b0;
    step(); en[2] = 1'b1;
    step(); chk("r6_start_tick", tick[2], 1'b1);
    step();
    en[2] = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      chk($sformatf("r6_stop_out_%0d", k), out[2], logic'(e6o[k]));
      chk($sformatf("r6_stop_tick_%0d", k), tick[2], 1'b0);
    end

    $display("scenario: sync channels 0 and 1");
    load[0] = 1'b1; set_ratio(0, 4);
    load[1] = 1'b1; set_ratio(1, 6);
    step(); load = '0;
    repeat (12) step();
    sync = 1'b1;
    step(); sync = 1'b0;
    chk("sync_tick0", tick[0], 1'b1); chk("sync_tick1", tick[1], 1'b1);
    chk("sync_out0", out[0], 1'b1);   chk("sync_out1", out[1], 1'b1);
    chk("sync_idle_out2", out[2], 1'b0);
    repeat (3) step();
    step(); chk("sync_p4_tick0", tick[0], 1'b1); chk("sync_p4_tick1", tick[1], 1'b0);
    step();
    step(); chk("sync_p6_tick1", tick[1], 1'b1); chk("sync_p6_tick0", tick[0], 1'b0);

    $display("scenario: sync applies pending ratio and stops disabled channel");
    load[0] = 1'b1; set_ratio(0, 3);
    step(); load[0] = 1'b0;
    chk("syncp_pend0", pend[0], 1'b1);
    sync = 1'b1; en[1] = 1'b0;
    step(); sync = 1'b0;
    chk("syncp_pend_clr", pend[0], 1'b0); chk("syncp_tick0", tick[0], 1'b1);
    chk("syncp_out1_stop", out[1], 1'b0); chk("syncp_tick1_stop", tick[1], 1'b0);
    step(); step();
    step(); chk("syncp_r3_tick0", tick[0], 1'b1);

    $display("scenario: load 0 stops channel 0");
    load[0] = 1'b1; set_ratio(0, 0);
    step(); load[0] = 1'b0;
    chk("zero_pend", pend[0], 1'b1);
    repeat (4) step();
    chk("zero_out", out[0], 1'b0); chk("zero_tick", tick[0], 1'b0); chk("zero_pend_clr", pend[0], 1'b0);
    step(); chk("zero_out_stays", out[0], 1'b0);

    $display("scenario: ratio 1 behaves as 2 on channel 3");
    load[3] = 1'b1; set_ratio(3, 1);
    step(); load[3] = 1'b0;
    step(); en[3] = 1'b1;
    step(); chk("r1_out_c1", out[3], 1'b1); chk("r1_tick_c1", tick[3], 1'b1);
    step(); chk("r1_out_c2", out[3], 1'b0); chk("r1_tick_c2", tick[3], 1'b0);
    step(); chk("r1_out_c3", out[3], 1'b1); chk("r1_tick_c3", tick[3], 1'b1);

    $display("scenario: reset mid-period restores default ratio");
    load[3] = 1'b1; set_ratio(3, 5);
    step(); load[3] = 1'b0;
    repeat (3) step();
    load[0] = 1'b1; set_ratio(0, 9); en[0] = 1'b1;
    rst = 1'b1;
    step(); load[0] = 1'b0;
    chk("rst_mid_quiet", |{out, tick, pend}, 1'b0);
    rst = 1'b0;
    step(); chk("post_rst_out3", out[3], 1'b1); chk("post_rst_tick3", tick[3], 1'b1);
    chk("post_rst_out0", out[0], 1'b1);
    step(); chk("post_rst_out3_low", out[3], 1'b0);
    step(); chk("post_rst_out3_hi", out[3], 1'b1); chk("post_rst_tick3_b", tick[3], 1'b1);
    repeat (4) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
